// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for the core's MUL instruction: one partial product per cycle,
// stalls the PC while running and presents the low WIDTH product bits in a single done cycle.
module mul_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          result_d = acc_d;
          state_d  = StDone;
        end
      end
      // start is still held by the retiring MUL here, so it must not be re-accepted.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= (state_d == StRun);
      done_q   <= (state_d == StDone);
    end
  end

  assign stall  = ((state_q == StIdle) && start && !rst) || (state_q == StRun);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes expected products, a negedge monitor pops them
// on every done pulse; per-cycle stall/busy/done timing is checked by the stimulus process.
module tb_mul_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         stall, busy, done;
  logic [W-1:0] result;

  int n_pass = 0;
  int n_total = 0;
  int done_pulses = 0;
  logic prev_done = 1'b0;
  logic [W-1:0] sb[$];

  mul_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_pulses++;
        if (sb.size() == 0) check("unexpected_done", 1'b1, 1'b0);
        else check("result", result, sb.pop_front());
        if (prev_done) check("done_twice", 1'b1, 1'b0);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one MUL from IDLE and check the full occupancy window, cycle 0..W+1.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp);
    sb.push_back(exp);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    for (int c = 0; c <= int'(W) + 1; c++) begin
      if (c == 1) begin
        op_a = ~a;
        op_b = ~b;
      end
      @(negedge clk);
      check("stall", stall, W'(c <= int'(W)));
      check("busy", busy, W'(c >= 1 && c <= int'(W)));
      check("done", done, W'(c == int'(W) + 1));
      next_cycle();
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    logic [W-1:0] held;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_stall", stall, '0);
    check("rst_busy", busy, '0);
    check("rst_done", done, '0);
    check("rst_result", result, '0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_mul(32'd6, 32'd7, 32'd42);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_mul(32'h1234_5678, 32'h0000_0010, 32'h2345_6780);

    // Back-to-back: start held through DONE; second MUL is accepted in cycle W+2.
    base = done_pulses;
    sb.push_back(32'd12);
    sb.push_back(32'd30);
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd4;
    for (int c = 0; c <= 2 * int'(W) + 3; c++) begin
      if (c == int'(W) + 1) begin
        op_a = 32'd5;
        op_b = 32'd6;
      end
      @(negedge clk);
      check("b2b_done", done, W'(c == int'(W) + 1 || c == 2 * int'(W) + 3));
      check("b2b_stall", stall, W'(c <= int'(W) || (c >= int'(W) + 2 && c <= 2 * int'(W) + 2)));
      next_cycle();
    end
    start = 1'b0;
    next_cycle();
    check("b2b_pulses", W'(done_pulses - base), W'(2));

    // Reset in cycle 10 of a 9*9 run: operation is dropped with no done pulse.
    base  = done_pulses;
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'd9;
    for (int c = 0; c < 10; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, '0);
    check("mid_rst_result", result, '0);
    check("mid_rst_stall", stall, '0);
    check("mid_rst_done", done, '0);
    for (int c = 0; c < 40; c++) next_cycle();
    check("mid_rst_no_done", W'(done_pulses - base), '0);
    run_mul(32'd2, 32'd3, 32'd6);

    // Idle stability: operands change freely, nothing moves.
    held = 32'd6;
    for (int c = 0; c < 50; c++) begin
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
      check("idle_stall", stall, '0);
      check("idle_busy", busy, '0);
      check("idle_done", done, '0);
      check("idle_result", result, held);
      next_cycle();
    end

    check("sb_empty", W'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
